// File: rtl/counter_firewall_param_if.sv
// Command and error-report bundle between a counter DUT driver and its firewall checker.
interface counter_firewall_param_if #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 ld;
    logic                 inc;
    logic                 dec;
    logic [WIDTH-1:0]     data_in;
    logic [WIDTH-1:0]     data_out;
    logic                 err_clr;

    logic                 err_mismatch;
    logic                 err_ovf;
    logic                 err_unf;
    logic                 err_cmd;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [2:0]           first_err;

    modport master (
        output ld, inc, dec, data_in, data_out, err_clr,
        input  err_mismatch, err_ovf, err_unf, err_cmd, err_pulse, err_count, first_err
    );

    modport slave (
        input  ld, inc, dec, data_in, data_out, err_clr,
        output err_mismatch, err_ovf, err_unf, err_cmd, err_pulse, err_count, first_err
    );
endinterface

// File: rtl/counter_firewall_param.sv
// Firewall checker: tracks a reference model of an up/down loadable counter and
// reports mismatches, overflow, underflow and illegal commands.
module counter_firewall_param #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned ERR_CNT_W = 8,
    parameter bit          WRAP_OK   = 1'b0,
    parameter bit          RESYNC    = 1'b1,
    parameter bit          MSG_EN    = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    counter_firewall_param_if.slave bus
);

    localparam logic [WIDTH-1:0]     MODEL_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_MIS  = 3'd1;
    localparam logic [2:0] CODE_CMD  = 3'd2;
    localparam logic [2:0] CODE_OVF  = 3'd3;
    localparam logic [2:0] CODE_UNF  = 3'd4;

    logic [WIDTH-1:0]     model_q, model_d;
    logic                 mis_q, mis_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 cmd_q, cmd_d;
    logic                 pulse_q, pulse_d;
    logic [ERR_CNT_W-1:0] count_q, count_d;
    logic [2:0]           first_q, first_d;

    logic                 mismatch_c;
    logic                 cmd_err_c;
    logic                 ovf_c;
    logic                 unf_c;
    logic                 any_err_c;
    logic [WIDTH-1:0]     model_base;
    logic [ERR_CNT_W-1:0] count_base;
    logic [2:0]           first_base;

    // Per-cycle error detection against the pre-edge model
    always_comb begin
        mismatch_c = (bus.data_out != model_q);
        cmd_err_c  = !bus.ld && bus.inc && bus.dec;
        ovf_c      = !WRAP_OK && !bus.ld && bus.inc && !bus.dec && (model_q == MODEL_MAX);
        unf_c      = !WRAP_OK && !bus.ld && bus.dec && !bus.inc && (model_q == '0);
        any_err_c  = mismatch_c | cmd_err_c | ovf_c | unf_c;
    end

    // Reference model next value; always wraps so it follows a wrapping DUT
    always_comb begin
        model_base = (RESYNC && mismatch_c) ? bus.data_out : model_q;
        model_d    = model_base;
        if (bus.ld) begin
            model_d = bus.data_in;
        end else if (bus.inc && bus.dec) begin
            model_d = model_base;
        end else if (bus.inc) begin
            model_d = model_base + WIDTH'(1);
        end else if (bus.dec) begin
            model_d = model_base - WIDTH'(1);
        end
    end

    // Error state next value: clear first, then record this cycle's errors
    always_comb begin
        mis_d      = bus.err_clr ? 1'b0 : mis_q;
        ovf_d      = bus.err_clr ? 1'b0 : ovf_q;
        unf_d      = bus.err_clr ? 1'b0 : unf_q;
        cmd_d      = bus.err_clr ? 1'b0 : cmd_q;
        count_base = bus.err_clr ? '0 : count_q;
        first_base = bus.err_clr ? CODE_NONE : first_q;
        count_d    = count_base;
        first_d    = first_base;
        pulse_d    = any_err_c;

        mis_d = mis_d | mismatch_c;
        ovf_d = ovf_d | ovf_c;
        unf_d = unf_d | unf_c;
        cmd_d = cmd_d | cmd_err_c;

        if (any_err_c && (count_base != CNT_MAX)) begin
            count_d = count_base + ERR_CNT_W'(1);
        end

        if (any_err_c && (first_base == CODE_NONE)) begin
            if (mismatch_c) begin
                first_d = CODE_MIS;
            end else if (cmd_err_c) begin
                first_d = CODE_CMD;
            end else if (ovf_c) begin
                first_d = CODE_OVF;
            end else begin
                first_d = CODE_UNF;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            model_q <= '0;
            mis_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cmd_q   <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            first_q <= CODE_NONE;
        end else begin
            model_q <= model_d;
            mis_q   <= mis_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cmd_q   <= cmd_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign bus.err_mismatch = mis_q;
    assign bus.err_ovf      = ovf_q;
    assign bus.err_unf      = unf_q;
    assign bus.err_cmd      = cmd_q;
    assign bus.err_pulse    = pulse_q;
    assign bus.err_count    = count_q;
    assign bus.first_err    = first_q;

`ifndef SYNTHESIS
    // Simulation-only trace of every errored edge
    always_ff @(posedge clk) begin
        if (MSG_EN && rst && any_err_c) begin
            $display("%0t counter_firewall_param: err mis=%0b cmd=%0b ovf=%0b unf=%0b model=%0d data_out=%0d",
                     $time, mismatch_c, cmd_err_c, ovf_c, unf_c, model_q, bus.data_out);
        end
    end
`endif

endmodule

// File: tb/tb_counter_firewall_param.sv
// Directed bench for counter_firewall_param: a vector table on the default
// configuration plus short sequences for wrap, free-run and saturation variants.
module tb_counter_firewall_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld, inc, dec, err_clr;
    logic [2:0] data_in, data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_firewall_param_if #(.WIDTH(3), .ERR_CNT_W(8)) if_main  ();
    counter_firewall_param_if #(.WIDTH(3), .ERR_CNT_W(8)) if_wrap  ();
    counter_firewall_param_if #(.WIDTH(3), .ERR_CNT_W(8)) if_nores ();
    counter_firewall_param_if #(.WIDTH(3), .ERR_CNT_W(2)) if_sat   ();

    assign if_main.ld  = ld;  assign if_main.inc  = inc; assign if_main.dec  = dec;
    assign if_main.data_in  = data_in;  assign if_main.data_out  = data_out;  assign if_main.err_clr  = err_clr;
    assign if_wrap.ld  = ld;  assign if_wrap.inc  = inc; assign if_wrap.dec  = dec;
    assign if_wrap.data_in  = data_in;  assign if_wrap.data_out  = data_out;  assign if_wrap.err_clr  = err_clr;
    assign if_nores.ld = ld;  assign if_nores.inc = inc; assign if_nores.dec = dec;
    assign if_nores.data_in = data_in;  assign if_nores.data_out = data_out;  assign if_nores.err_clr = err_clr;
    assign if_sat.ld   = ld;  assign if_sat.inc   = inc; assign if_sat.dec   = dec;
    assign if_sat.data_in   = data_in;  assign if_sat.data_out   = data_out;  assign if_sat.err_clr   = err_clr;

    counter_firewall_param #(.WIDTH(3), .ERR_CNT_W(8), .WRAP_OK(1'b0), .RESYNC(1'b1), .MSG_EN(1'b1))
        u_main (.clk(clk), .rst(rst), .bus(if_main));
    counter_firewall_param #(.WIDTH(3), .ERR_CNT_W(8), .WRAP_OK(1'b1), .RESYNC(1'b1), .MSG_EN(1'b0))
        u_wrap (.clk(clk), .rst(rst), .bus(if_wrap));
    counter_firewall_param #(.WIDTH(3), .ERR_CNT_W(8), .WRAP_OK(1'b0), .RESYNC(1'b0), .MSG_EN(1'b0))
        u_nores (.clk(clk), .rst(rst), .bus(if_nores));
    counter_firewall_param #(.WIDTH(3), .ERR_CNT_W(2), .WRAP_OK(1'b0), .RESYNC(1'b1), .MSG_EN(1'b0))
        u_sat (.clk(clk), .rst(rst), .bus(if_sat));

    typedef struct {
        logic       rst, ld, inc, dec;
        logic [2:0] din, dout;
        logic       clr;
        logic       mis, ovf, unf, cmd, pulse;
        int         cnt;
        int         first;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic r, input logic l, input logic i, input logic d,
                                input logic [2:0] di, input logic [2:0] dout, input logic c,
                                input logic mis, input logic ovf, input logic unf, input logic cmd,
                                input logic pulse, input int cnt, input int first);
        vec_t v;
        v.rst = r; v.ld = l; v.inc = i; v.dec = d; v.din = di; v.dout = dout; v.clr = c;
        v.mis = mis; v.ovf = ovf; v.unf = unf; v.cmd = cmd; v.pulse = pulse;
        v.cnt = cnt; v.first = first;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic i, input logic d,
                         input logic [2:0] di, input logic [2:0] dout, input logic c);
        rst = r; ld = l; inc = i; dec = d; data_in = di; data_out = dout; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst ld inc dec din dout clr  mis ovf unf cmd pul cnt first
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // reset
        vecs[1]  = mk(1, 1, 0, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0); // ld 5
        vecs[2]  = mk(1, 0, 1, 0, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0); // inc, out 5
        vecs[3]  = mk(1, 0, 1, 0, 0, 6, 0,  0, 0, 0, 0, 0, 0, 0); // inc, out 6
        vecs[4]  = mk(1, 0, 1, 0, 0, 7, 0,  0, 1, 0, 0, 1, 1, 3); // inc at 7: overflow
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 3); // wrapped to 0, pulse drops
        vecs[6]  = mk(1, 1, 0, 0, 6, 0, 0,  0, 1, 0, 0, 0, 1, 3); // ld 6
        vecs[7]  = mk(1, 0, 1, 1, 0, 6, 0,  0, 1, 0, 1, 1, 2, 3); // inc&dec: illegal, hold 6
        vecs[8]  = mk(1, 1, 1, 1, 1, 6, 0,  0, 1, 0, 1, 0, 2, 3); // ld wins: legal, model 1
        vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 2, 3); // out 1 matches
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0); // clean clear
        vecs[11] = mk(1, 1, 0, 0, 2, 1, 0,  0, 0, 0, 0, 0, 0, 0); // ld 2
        vecs[12] = mk(1, 0, 1, 0, 0, 4, 0,  1, 0, 0, 0, 1, 1, 1); // forced 4: mismatch, resync -> 5
        vecs[13] = mk(1, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 1, 1); // out 5 agrees
        vecs[14] = mk(1, 1, 0, 0, 0, 5, 0,  1, 0, 0, 0, 0, 1, 1); // ld 0
        vecs[15] = mk(1, 0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 1, 2, 1); // dec at 0: underflow
        vecs[16] = mk(1, 0, 0, 0, 0, 7, 0,  1, 0, 1, 0, 0, 2, 1); // wrapped to 7
        vecs[17] = mk(0, 0, 1, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0); // reset mid-run
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0); // model back at 0
        vecs[19] = mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 4); // underflow
        vecs[20] = mk(1, 0, 0, 0, 0, 2, 1,  1, 0, 0, 0, 1, 1, 1); // clear + mismatch
        vecs[21] = mk(1, 0, 0, 0, 0, 2, 0,  1, 0, 0, 0, 0, 1, 1); // resynced to 2

        rst = 1'b0; ld = 1'b0; inc = 1'b0; dec = 1'b0;
        data_in = '0; data_out = '0; err_clr = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 22; k++) begin
            drive(vecs[k].rst, vecs[k].ld, vecs[k].inc, vecs[k].dec,
                  vecs[k].din, vecs[k].dout, vecs[k].clr);
            chk($sformatf("v%0d err_mismatch", k), int'(if_main.err_mismatch), int'(vecs[k].mis));
            chk($sformatf("v%0d err_ovf", k),      int'(if_main.err_ovf),      int'(vecs[k].ovf));
            chk($sformatf("v%0d err_unf", k),      int'(if_main.err_unf),      int'(vecs[k].unf));
            chk($sformatf("v%0d err_cmd", k),      int'(if_main.err_cmd),      int'(vecs[k].cmd));
            chk($sformatf("v%0d err_pulse", k),    int'(if_main.err_pulse),    int'(vecs[k].pulse));
            chk($sformatf("v%0d err_count", k),    int'(if_main.err_count),    vecs[k].cnt);
            chk($sformatf("v%0d first_err", k),    int'(if_main.first_err),    vecs[k].first);
        end

        // Underflow legal under wrap: DUT goes 0 -> 7
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 7, 0);
        chk("wrap err_unf",     int'(if_wrap.err_unf),   0);
        chk("wrap err_count",   int'(if_wrap.err_count), 0);
        chk("wrap err_mismatch", int'(if_wrap.err_mismatch), 0);
        chk("nowrap err_unf",   int'(if_main.err_unf),   1);
        chk("nowrap first_err", int'(if_main.first_err), 4);
        chk("nowrap err_count", int'(if_main.err_count), 1);

        // Free-running model keeps disagreeing after a forced value
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 2, 0, 0);
        drive(1, 0, 1, 0, 0, 4, 0);
        chk("nores first mismatch", int'(if_nores.err_count), 1);
        chk("nores first_err",      int'(if_nores.first_err), 1);
        drive(1, 0, 0, 0, 0, 5, 0);
        chk("nores repeat count",   int'(if_nores.err_count), 2);
        chk("nores repeat pulse",   int'(if_nores.err_pulse), 1);
        chk("resync count",         int'(if_main.err_count),  1);
        chk("resync pulse",         int'(if_main.err_pulse),  0);

        // Saturation on a 2-bit error counter, then both flavours of clear
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            drive(1, 0, 0, 0, 0, 3'(n), 0);
            if (n == 3) chk("sat count at 3", int'(if_sat.err_count), 3);
        end
        chk("sat count held",   int'(if_sat.err_count), 3);
        chk("sat first_err",    int'(if_sat.first_err), 1);
        drive(1, 0, 0, 0, 0, 5, 1);
        chk("clean clr count",    int'(if_sat.err_count),    0);
        chk("clean clr first",    int'(if_sat.first_err),    0);
        chk("clean clr mismatch", int'(if_sat.err_mismatch), 0);
        chk("clean clr pulse",    int'(if_sat.err_pulse),    0);
        drive(1, 0, 0, 0, 0, 6, 1);
        chk("clr+err count",    int'(if_sat.err_count),    1);
        chk("clr+err first",    int'(if_sat.first_err),    1);
        chk("clr+err mismatch", int'(if_sat.err_mismatch), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
